ht_fifo_rd_stream: RTL and testbench



---
 rtl/ht_fifo_rd_stream_if.sv | 27 ++
 rtl/ht_fifo_rd_stream.sv | 87 ++++++++
 tb/tb_ht_fifo_rd_stream.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ht_fifo_rd_stream_if.sv
// Read-side stream bundle between the hash-table FIFO, the read adapter and its consumer.
// Latency: none (wires only); the adapter fixes the pop-to-valid latency.
// Backpressure: ready_i from the consumer; the adapter meters fifo_rd_req_o against buffer credit.
// Signals: fifo_empty_i / fifo_rd_data_i / fifo_rd_req_o face the FIFO,
//          data_o / valid_o / ready_i face the consumer, busy_o reports buffered or in-flight words.
// master = adapter view, slave = FIFO + consumer view.
interface ht_fifo_rd_stream_if #(
    parameter int DATA_W = 10
);
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_rd_data_i;
    logic              fifo_rd_req_o;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;

    modport master (
        input  fifo_empty_i, fifo_rd_data_i, ready_i,
        output fifo_rd_req_o, data_o, valid_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_rd_data_i, ready_i,
        input  fifo_rd_req_o, data_o, valid_o, busy_o
    );
endinterface

// File: rtl/ht_fifo_rd_stream.sv
// Pops the hash-table FIFO and re-times its fixed-latency read data into a valid/ready stream.
// Latency: pop in cycle T, data captured in T+RD_LATENCY, valid_o from T+RD_LATENCY+1; one word/clk sustained.
// Backpressure: pops are credit-limited to RD_LATENCY+1 buffer slots, so in-flight words always have a home.
// Ports: clk_i, rst_n_i (sync, active-low), flush_i (sync drop of buffered/in-flight words),
//        rd (master modport): FIFO pop/empty/data, stream data/valid/ready, busy.
module ht_fifo_rd_stream #(
    parameter int DATA_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    ht_fifo_rd_stream_if.master     rd
);
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W     = $clog2(BUF_DEPTH);

    // One bit per clock of read latency; the top bit marks "FIFO data is on the bus now".
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [CNT_W-1:0]      occ_cnt;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_W-1:0]     buf_mem [BUF_DEPTH];
    logic                  pop_out;
    logic                  arrive;
    logic                  rd_req;
    logic [CNT_W:0]        in_use;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(vld_pipe[i]);
        end
    end

    assign arrive  = vld_pipe[RD_LATENCY-1];
    assign pop_out = rd.valid_o && rd.ready_i;

    // Slots committed after this edge if nothing new were popped. Crediting the
    // beat leaving this cycle keeps a full buffer streaming at one word per clock.
    // pop_out implies occ_cnt >= 1, so the subtraction cannot underflow.
    assign in_use = {1'b0, occ_cnt} + {1'b0, inflight_cnt} - {{CNT_W{1'b0}}, pop_out};

    // Reset and flush both gate the pop so nothing is issued into a pipe being cleared.
    assign rd_req = rst_n_i && !flush_i && !rd.fifo_empty_i &&
                    (in_use < (CNT_W+1)'(BUF_DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            vld_pipe <= '0;
            occ_cnt  <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
        end else begin
            vld_pipe[0] <= rd_req;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end

            if (arrive) begin
                buf_mem[wr_idx] <= rd.fifo_rd_data_i;
                wr_idx          <= idx_inc(wr_idx);
            end

            if (pop_out) begin
                rd_idx <= idx_inc(rd_idx);
            end

            case ({arrive, pop_out})
                2'b10:   occ_cnt <= occ_cnt + 1'b1;
                2'b01:   occ_cnt <= occ_cnt - 1'b1;
                default: occ_cnt <= occ_cnt;
            endcase
        end
    end

    assign rd.fifo_rd_req_o = rd_req;
    assign rd.valid_o       = (occ_cnt != '0);
    assign rd.data_o        = buf_mem[rd_idx];
    assign rd.busy_o        = (occ_cnt != '0) || (vld_pipe != '0);
endmodule

// File: tb/tb_ht_fifo_rd_stream.sv
// Bench for ht_fifo_rd_stream: one instance at RD_LATENCY=1 and one at RD_LATENCY=3,
// each fed by a behavioural FIFO with matching read latency; expected words go into
// a queue when pushed and are compared as the stream hands them out.
module tb_ht_fifo_rd_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    ht_fifo_rd_stream_if #(.DATA_W(10)) ifa ();
    ht_fifo_rd_stream_if #(.DATA_W(10)) ifb ();

    ht_fifo_rd_stream #(.DATA_W(10), .RD_LATENCY(1)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush_a),
        .rd      (ifa)
    );

    ht_fifo_rd_stream #(.DATA_W(10), .RD_LATENCY(3)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush_b),
        .rd      (ifb)
    );

    // Behavioural FIFOs: words written by the stimulus, popped on fifo_rd_req_o.
    logic [9:0] src_a [64];
    logic [9:0] src_b [64];
    int         wr_cnt_a = 0;
    int         wr_cnt_b = 0;
    int         rd_ptr_a = 0;
    int         rd_ptr_b = 0;
    logic [9:0] rd_data_a = '0;
    logic [9:0] d1 = '0, d2 = '0, d3 = '0;
    int         out_a = 0;
    int         out_b = 0;

    assign ifa.fifo_empty_i   = (rd_ptr_a == wr_cnt_a);
    assign ifb.fifo_empty_i   = (rd_ptr_b == wr_cnt_b);
    assign ifa.fifo_rd_data_i = rd_data_a;
    assign ifb.fifo_rd_data_i = d3;

    logic ready_a = 1'b0;
    logic ready_b = 1'b0;
    assign ifa.ready_i = ready_a;
    assign ifb.ready_i = ready_b;

    always @(posedge clk) begin
        // Off-cycle read data is random so a DUT sampling at the wrong time shows up.
        if (ifa.fifo_rd_req_o && rd_ptr_a < wr_cnt_a) begin
            rd_data_a <= src_a[rd_ptr_a];
            rd_ptr_a  <= rd_ptr_a + 1;
        end else begin
            rd_data_a <= 10'($urandom);
        end
        if (ifb.fifo_rd_req_o && rd_ptr_b < wr_cnt_b) begin
            d1       <= src_b[rd_ptr_b];
            rd_ptr_b <= rd_ptr_b + 1;
        end else begin
            d1 <= 10'($urandom);
        end
        d2 <= d1;
        d3 <= d2;
        // Outstanding words = pops issued minus beats consumed.
        if (!rst_n || flush_a) out_a <= 0;
        else out_a <= out_a + (ifa.fifo_rd_req_o ? 1 : 0) - ((ifa.valid_o && ifa.ready_i) ? 1 : 0);
        if (!rst_n || flush_b) out_b <= 0;
        else out_b <= out_b + (ifb.fifo_rd_req_o ? 1 : 0) - ((ifb.valid_o && ifb.ready_i) ? 1 : 0);
    end

    always @(negedge clk) begin
        assert (out_a <= 2) else $error("FAIL credit_a outstanding=%0d max=2", out_a);
        assert (out_b <= 4) else $error("FAIL credit_b outstanding=%0d max=4", out_b);
    end

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_a [$];
    logic [9:0] exp_b [$];
    logic [9:0] exp_w;
    int         beats;

    task automatic push_a(input logic [9:0] w);
        src_a[wr_cnt_a] = w;
        wr_cnt_a        = wr_cnt_a + 1;
        exp_a.push_back(w);
    endtask

    task automatic push_b(input logic [9:0] w);
        src_b[wr_cnt_b] = w;
        wr_cnt_b        = wr_cnt_b + 1;
        exp_b.push_back(w);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) push_a(10'(i));
        #1;
        checks++;
        if (ifa.valid_o !== 1'b0 || ifa.busy_o !== 1'b0 || ifa.fifo_rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_a valid=%b busy=%b req=%b expected 0 0 0",
                     ifa.valid_o, ifa.busy_o, ifa.fifo_rd_req_o);
        end
        checks++;
        if (ifb.valid_o !== 1'b0 || ifb.busy_o !== 1'b0 || ifb.fifo_rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_b valid=%b busy=%b req=%b expected 0 0 0",
                     ifb.valid_o, ifb.busy_o, ifb.fifo_rd_req_o);
        end
    endtask

    // Four preloaded words, ready held high: pop in cycle 0, beats in cycles 2..5.
    task automatic test_basic_latency();
        @(negedge clk);
        rst_n   = 1'b1;
        ready_a = 1'b1;
        beats   = 0;
        #1;
        checks++;
        if (ifa.fifo_rd_req_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_pop req=%b expected 1", ifa.fifo_rd_req_o);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (ifa.valid_o !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL basic_valid cycle=%0d valid=%b expected %b", c, ifa.valid_o, (c >= 2 && c <= 5));
            end
            if (ifa.valid_o && ifa.ready_i) begin
                checks++;
                exp_w = (exp_a.size() != 0) ? exp_a.pop_front() : 10'h3ff;
                if (ifa.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL basic_data cycle=%0d data=%h expected %h", c, ifa.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 4 || ifa.busy_o !== 1'b0 || ifa.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain beats=%0d busy=%b valid=%b expected 4 0 0", beats, ifa.busy_o, ifa.valid_o);
        end
    endtask

    // Ten words under stall: only two pops, head word held, then a gapless drain.
    task automatic test_backpressure();
        int p0;
        int held;
        @(negedge clk);
        ready_a = 1'b0;
        p0      = rd_ptr_a;
        for (int i = 0; i < 10; i++) push_a(10'h010 + 10'(i));
        held = 0;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ifa.valid_o) begin
                held++;
                checks++;
                if (ifa.data_o !== exp_a[0]) begin
                    errors++;
                    $display("FAIL bp_hold cycle=%0d data=%h expected %h", c, ifa.data_o, exp_a[0]);
                end
            end
        end
        checks++;
        if (rd_ptr_a - p0 != 2) begin
            errors++;
            $display("FAIL bp_pops issued=%0d expected 2", rd_ptr_a - p0);
        end
        checks++;
        if (held != 23) begin
            errors++;
            $display("FAIL bp_valid_cycles got=%0d expected 23", held);
        end
        beats = 0;
        for (int c = 0; c < 40 && beats < 10; c++) begin
            @(negedge clk);
            ready_a = 1'b1;
            #1;
            if (beats > 0) begin
                checks++;
                if (ifa.valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_gap after_beat=%0d valid=%b expected 1", beats, ifa.valid_o);
                end
            end
            if (ifa.valid_o && ifa.ready_i) begin
                checks++;
                exp_w = (exp_a.size() != 0) ? exp_a.pop_front() : 10'h3ff;
                if (ifa.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL bp_data beat=%0d data=%h expected %h", beats, ifa.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 10) begin
            errors++;
            $display("FAIL bp_count beats=%0d expected 10", beats);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ifa.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle busy=%b expected 0", ifa.busy_o);
        end
    endtask

    // Ready alternating every cycle over eight words.
    task automatic test_toggle_ready();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_a(10'h020 + 10'(i));
        beats = 0;
        for (int c = 0; c < 60 && beats < 8; c++) begin
            if (c > 0) @(negedge clk);
            ready_a = (c % 2 == 0);
            #1;
            checks++;
            if (out_a > 2) begin
                errors++;
                $display("FAIL toggle_credit cycle=%0d outstanding=%0d max 2", c, out_a);
            end
            if (ifa.valid_o && ifa.ready_i) begin
                checks++;
                exp_w = (exp_a.size() != 0) ? exp_a.pop_front() : 10'h3ff;
                if (ifa.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL toggle_data beat=%0d data=%h expected %h", beats, ifa.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL toggle_count beats=%0d expected 8", beats);
        end
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ifa.busy_o !== 1'b0 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL toggle_idle busy=%b left=%0d expected 0 0", ifa.busy_o, exp_a.size());
        end
    endtask

    // RD_LATENCY=3: first pop in cycle 0, beats in cycles 4..19 back to back.
    task automatic test_latency3();
        @(negedge clk);
        ready_b = 1'b1;
        for (int i = 0; i < 16; i++) push_b(10'h100 + 10'(i));
        beats = 0;
        #1;
        checks++;
        if (ifb.fifo_rd_req_o !== 1'b1) begin
            errors++;
            $display("FAIL lat3_first_pop req=%b expected 1", ifb.fifo_rd_req_o);
        end
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (ifb.valid_o !== (c >= 4 && c <= 19)) begin
                errors++;
                $display("FAIL lat3_valid cycle=%0d valid=%b expected %b", c, ifb.valid_o, (c >= 4 && c <= 19));
            end
            if (ifb.valid_o && ifb.ready_i) begin
                checks++;
                exp_w = (exp_b.size() != 0) ? exp_b.pop_front() : 10'h3ff;
                if (ifb.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL lat3_data cycle=%0d data=%h expected %h", c, ifb.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 16 || ifb.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL lat3_drain beats=%0d busy=%b expected 16 0", beats, ifb.busy_o);
        end
    endtask

    // Flush with two words buffered and one still in the read pipe of the latency-3 instance.
    task automatic test_flush();
        @(negedge clk);
        ready_b = 1'b0;
        push_b(10'h030);
        push_b(10'h031);
        repeat (4) @(negedge clk);
        push_b(10'h032);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ifb.valid_o !== 1'b1 || ifb.data_o !== 10'h030 || ifb.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre valid=%b data=%h busy=%b expected 1 030 1",
                     ifb.valid_o, ifb.data_o, ifb.busy_o);
        end
        flush_b = 1'b1;
        exp_b.delete();
        push_b(10'h0AA);
        #1;
        checks++;
        if (ifb.fifo_rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req req=%b expected 0", ifb.fifo_rd_req_o);
        end
        @(negedge clk);
        flush_b = 1'b0;
        #1;
        checks++;
        if (ifb.valid_o !== 1'b0 || ifb.busy_o !== 1'b0 || ifb.fifo_rd_req_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_post valid=%b busy=%b req=%b expected 0 0 1",
                     ifb.valid_o, ifb.busy_o, ifb.fifo_rd_req_o);
        end
        ready_b = 1'b1;
        beats   = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (ifb.valid_o && ifb.ready_i) begin
                checks++;
                exp_w = (exp_b.size() != 0) ? exp_b.pop_front() : 10'h3ff;
                if (ifb.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL flush_data data=%h expected %h", ifb.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 1) begin
            errors++;
            $display("FAIL flush_count beats=%0d expected 1", beats);
        end
    endtask

    // One-cycle reset with two words buffered and the FIFO empty.
    task automatic test_reset_mid();
        @(negedge clk);
        ready_a = 1'b0;
        push_a(10'h050);
        push_a(10'h051);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (ifa.valid_o !== 1'b1 || ifa.fifo_empty_i !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre valid=%b empty=%b expected 1 1", ifa.valid_o, ifa.fifo_empty_i);
        end
        rst_n = 1'b0;
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifa.valid_o !== 1'b0 || ifa.busy_o !== 1'b0 || ifa.fifo_rd_req_o !== 1'b0 ||
            ifb.valid_o !== 1'b0 || ifb.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post a_valid=%b a_busy=%b a_req=%b b_valid=%b b_busy=%b expected all 0",
                     ifa.valid_o, ifa.busy_o, ifa.fifo_rd_req_o, ifb.valid_o, ifb.busy_o);
        end
        ready_a = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ifa.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_spurious cycle=%0d valid=%b expected 0", c, ifa.valid_o);
            end
        end
        push_a(10'h0BB);
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (ifa.valid_o && ifa.ready_i) begin
                checks++;
                exp_w = (exp_a.size() != 0) ? exp_a.pop_front() : 10'h3ff;
                if (ifa.data_o !== exp_w) begin
                    errors++;
                    $display("FAIL rstmid_data data=%h expected %h", ifa.data_o, exp_w);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 1) begin
            errors++;
            $display("FAIL rstmid_count beats=%0d expected 1", beats);
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_backpressure();
        test_toggle_ready();
        test_latency3();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
